// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and line-level constants for the UART receiver
//
// Purpose: receiver FSM state encoding and the fixed line levels of a frame.
// Ports:   none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_PARITY,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-in / byte-out bundle of the UART receiver
//
// Purpose: groups the oversample strobe, serial line and received-byte outputs.
// Signals:
//   os_tick     oversample strobe (OVERSAMPLE x baud), 1 clk wide
//   rx          serial line, idle high, asynchronous to clk
//   rd_data     last received byte, held until the next frame completes
//   rd_valid    1-clk pulse when rd_data / parity_err / frame_err update
//   parity_err  parity mismatch on last frame (held)
//   frame_err   stop bit sampled low on last frame (held)
//   busy        receiver is inside a frame
// Modports: master drives the line side, slave is the receiver.

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 os_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output os_tick, rx,
    input  rd_data, rd_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  os_tick, rx,
    output rd_data, rd_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset level
//
// Purpose: brings an asynchronous single-bit input into the clk domain.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset; both flops load RESET_VAL
//   d_i  in   asynchronous input
//   q_o  out  synchronized output (2 clk latency)

module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, frame: start, parity, data MSB first, stop
//
// Purpose: recovers one character per frame from rx, sampling each bit at its
//          mid-point on the os_tick grid, and reports byte plus error flags.
// Ports:
//   clk  in     system clock
//   rst  in     asynchronous active-high reset
//   bus  slave  uart_rx_if: os_tick, rx in; rd_data, rd_valid, parity_err,
//               frame_err, busy out

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  rx_state_t            state_q,   state_d;
  logic [TICK_W-1:0]    tick_q,    tick_d;
  logic [BIT_W-1:0]     bit_q,     bit_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_q,     par_d;
  logic                 armed_q,   armed_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 valid_q,   valid_d;
  logic                 perr_q,    perr_d;
  logic                 ferr_q,    ferr_d;
  logic                 busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    armed_d   = armed_q;
    rd_data_d = rd_data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    busy_d    = busy_q;

    if (bus.os_tick) begin
      case (state_q)
        RX_IDLE: begin
          // After a bad stop bit the line must be seen idle once before a new
          // start edge is trusted; otherwise a break would stream 0x00 frames.
          if (!armed_q) begin
            if (rx_s == IDLE_LEVEL) armed_d = 1'b1;
          end else if (rx_s == START_BIT) begin
            state_d = RX_START;
            tick_d  = '0;
            busy_d  = 1'b1;
          end
        end
        RX_START: begin
          if (tick_q == HALF_TICK) begin
            if (rx_s != START_BIT) begin
              state_d = RX_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = RX_PARITY;
              tick_d  = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        RX_PARITY, RX_DATA, RX_STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (state_q == RX_PARITY) begin
              par_d   = rx_s;
              bit_d   = '0;
              state_d = RX_DATA;
            end else if (state_q == RX_DATA) begin
              shift_d = {shift_q[DATA_BITS-2:0], rx_s};
              bit_d   = bit_q + 1'b1;
              if (bit_q == LAST_BIT) state_d = RX_STOP;
            end else begin
              rd_data_d = shift_q;
              perr_d    = (^shift_q) != par_q;
              ferr_d    = (rx_s != STOP_BIT);
              valid_d   = 1'b1;
              armed_d   = (rx_s == STOP_BIT);
              busy_d    = 1'b0;
              state_d   = RX_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = RX_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      armed_q   <= 1'b1;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      armed_q   <= armed_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule
